// File: rtl/adc_sequencer.sv
// Conversion controller for the discrete ADC: sequences ramp-compare and SAR
// conversions against the R2R generator and reports one result per start.
module adc_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int RAMP_TIMEOUT  = 2_600_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_sel,
    input  logic             abort,
    input  logic             comp_in,
    input  logic [WIDTH-1:0] ramp_value,
    output logic             gen_enable,
    output logic             adc_mode,
    output logic             capture_en,
    output logic [WIDTH-1:0] sar_duty_cycle,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrange,
    output logic             busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > RAMP_TIMEOUT) ? SETTLE_CYCLES : RAMP_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]    SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(RAMP_TIMEOUT - 1);
    localparam logic [IW-1:0]    IDX_MSB      = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES     = {WIDTH{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_RAMP_ARM     = 4'd1,
        S_RAMP_RUN     = 4'd2,
        S_RAMP_CAPTURE = 4'd3,
        S_RAMP_LATCH   = 4'd4,
        S_SAR_SET      = 4'd5,
        S_SAR_WAIT     = 4'd6,
        S_SAR_DECIDE   = 4'd7,
        S_DONE         = 4'd8
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [WIDTH-1:0]       r_trial;
    logic [WIDTH-1:0]       r_pend_result;
    logic                   r_pend_ovr;

    logic             w_comp_s;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_trial_next;

    assign w_comp_s     = r_sync[SYNC_STAGES-1];
    assign w_bit_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;
    // sar_duty_cycle already carries the trial with bit i set, so a "keep" decision adopts it.
    assign w_trial_next = w_comp_s ? sar_duty_cycle : r_trial;

    // Comparator synchronizer chain; all decisions use its last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= {CW{1'b0}};
            r_idx          <= {IW{1'b0}};
            r_trial        <= {WIDTH{1'b0}};
            r_pend_result  <= {WIDTH{1'b0}};
            r_pend_ovr     <= 1'b0;
            gen_enable     <= 1'b0;
            adc_mode       <= 1'b0;
            capture_en     <= 1'b0;
            sar_duty_cycle <= {WIDTH{1'b0}};
            result         <= {WIDTH{1'b0}};
            result_valid   <= 1'b0;
            overrange      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            capture_en   <= 1'b0;
            result_valid <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state    <= S_IDLE;
                gen_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            adc_mode   <= mode_sel;
                            gen_enable <= 1'b1;
                            busy       <= 1'b1;
                            if (mode_sel) begin
                                r_state        <= S_SAR_SET;
                                r_idx          <= IDX_MSB;
                                r_trial        <= {WIDTH{1'b0}};
                                sar_duty_cycle <= {WIDTH{1'b0}};
                            end else begin
                                r_state <= S_RAMP_ARM;
                                r_cnt   <= SETTLE_LAST;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RAMP_ARM: begin
                        if (r_cnt == {CW{1'b0}}) begin
                            r_state <= S_RAMP_RUN;
                            r_cnt   <= {CW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    S_RAMP_RUN: begin
                        if (!w_comp_s) begin
                            r_state    <= S_RAMP_CAPTURE;
                            capture_en <= 1'b1;
                        end else if (r_cnt == TIMEOUT_LAST) begin
                            r_state       <= S_DONE;
                            r_pend_result <= ALL_ONES;
                            r_pend_ovr    <= 1'b1;
                            gen_enable    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_RAMP_CAPTURE: begin
                        r_state <= S_RAMP_LATCH;
                    end
                    // The generator registered its capture on the strobe cycle.
                    S_RAMP_LATCH: begin
                        r_state       <= S_DONE;
                        r_pend_result <= ramp_value;
                        r_pend_ovr    <= 1'b0;
                        gen_enable    <= 1'b0;
                    end
                    S_SAR_SET: begin
                        r_state        <= S_SAR_WAIT;
                        sar_duty_cycle <= r_trial | w_bit_mask;
                        r_cnt          <= SETTLE_LAST;
                    end
                    S_SAR_WAIT: begin
                        if (r_cnt == {CW{1'b0}}) begin
                            r_state <= S_SAR_DECIDE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    S_SAR_DECIDE: begin
                        if (r_idx == {IW{1'b0}}) begin
                            r_state       <= S_DONE;
                            r_pend_result <= w_trial_next;
                            r_pend_ovr    <= 1'b0;
                            gen_enable    <= 1'b0;
                        end else begin
                            r_state <= S_SAR_SET;
                            r_idx   <= r_idx - IW'(1);
                            r_trial <= w_trial_next;
                        end
                    end
                    // Result, overrange and the valid pulse update on the same edge.
                    S_DONE: begin
                        r_state      <= S_IDLE;
                        result       <= r_pend_result;
                        overrange    <= r_pend_ovr;
                        result_valid <= 1'b1;
                        gen_enable   <= 1'b0;
                        busy         <= 1'b0;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        gen_enable <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: a generator/comparator model drives the
// DUT, and a scoreboard of expected conversions checks outputs on every cycle.
module tb_adc_sequencer;

    localparam int W = 8;
    localparam int S = 4;
    localparam int T = 3000;

    logic         clk = 1'b0;
    logic         reset, start, mode_sel, abort, comp_in;
    logic [W-1:0] ramp_value = 8'h00;
    logic         gen_enable, adc_mode, capture_en, result_valid, overrange, busy;
    logic [W-1:0] sar_duty_cycle, result;

    always #5 clk = ~clk;

    adc_sequencer #(
        .WIDTH(W), .SETTLE_CYCLES(S), .RAMP_TIMEOUT(T), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel),
        .abort(abort), .comp_in(comp_in), .ramp_value(ramp_value),
        .gen_enable(gen_enable), .adc_mode(adc_mode), .capture_en(capture_en),
        .sar_duty_cycle(sar_duty_cycle), .result(result),
        .result_valid(result_valid), .overrange(overrange), .busy(busy)
    );

    // Generator model: ramp steps every 10 clocks while enabled, restarts at 0 when disabled.
    logic [W-1:0] gen_ramp = 8'h00;
    int           gen_div  = 0;
    logic [W-1:0] vin      = 8'h00;
    logic         comp_force = 1'b0;
    logic [W-1:0] r2r;

    always @(posedge clk) begin
        if (!gen_enable) begin
            gen_div  <= 0;
            gen_ramp <= 8'h00;
        end else if (gen_div == 9) begin
            gen_div  <= 0;
            gen_ramp <= gen_ramp + 8'd1;
        end else begin
            gen_div <= gen_div + 1;
        end
        if (capture_en) ramp_value <= gen_ramp;
    end

    assign r2r = adc_mode ? sar_duty_cycle : gen_ramp;
    // Vin sits half an LSB above its code, so the SAR converges onto the code itself.
    assign comp_in = comp_force | ({vin, 1'b1} > {r2r, 1'b0});

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           lo;
        int           hi;
        logic [W-1:0] rlo;
        logic [W-1:0] rhi;
        logic         ovr;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] trials[$];
    int           rv_count  = 0;
    int           cap_count = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    // Reference SAR search: trial k of a binary search that keeps a bit when Vin >= trial.
    function automatic logic [W-1:0] sar_trial(input logic [W-1:0] v, input int k);
        logic [W-1:0] acc;
        logic [W-1:0] t;
        acc = 8'h00;
        t   = 8'h00;
        for (int b = 0; b <= k; b++) begin
            t = acc | (8'h80 >> b);
            if (b < k && v >= t) acc = t;
        end
        return t;
    endfunction

    // Per-cycle compare against the scoreboard of expected conversions.
    initial begin
        logic [W-1:0] prev_res;
        logic         prev_ovr;
        logic [W-1:0] prev_duty;
        exp_t         e;
        prev_res  = 8'h00;
        prev_ovr  = 1'b0;
        prev_duty = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                if (result_valid) begin
                    checks++;
                    rv_count++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid at cycle %0d: result %h overrange %b", cyc, result, overrange);
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc < e.lo || cyc > e.hi || result < e.rlo || result > e.rhi || overrange !== e.ovr) begin
                            errors++;
                            $display("FAIL conversion at cycle %0d: result %h overrange %b, expected cycle %0d..%0d result %h..%h overrange %b",
                                     cyc, result, overrange, e.lo, e.hi, e.rlo, e.rhi, e.ovr);
                        end
                    end
                end else begin
                    checks++;
                    if (result !== prev_res || overrange !== prev_ovr) begin
                        errors++;
                        $display("FAIL result_hold at cycle %0d: result %h/%b, held %h/%b", cyc, result, overrange, prev_res, prev_ovr);
                    end
                    if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                        errors++;
                        $display("FAIL missing_valid at cycle %0d: result_valid absent, expected by cycle %0d", cyc, exp_q[0].hi);
                        exp_q.delete(0);
                    end
                end
                if (capture_en) begin
                    cap_count++;
                    checks++;
                    if (adc_mode) begin
                        errors++;
                        $display("FAIL capture_in_sar at cycle %0d: capture_en 1 with adc_mode 1", cyc);
                    end
                end
                if (busy && adc_mode && sar_duty_cycle != prev_duty && sar_duty_cycle != 8'h00)
                    trials.push_back(sar_duty_cycle);
            end
            prev_res  = result;
            prev_ovr  = overrange;
            prev_duty = sar_duty_cycle;
        end
    end

    task automatic check_trials(input logic [W-1:0] v, input int convs);
        check("trial_count", 32'(trials.size()), 32'(8 * convs));
        for (int k = 0; k < trials.size() && k < 8 * convs; k++)
            check("sar_trial", 32'(trials[k]), 32'(sar_trial(v, k % 8)));
    endtask

    task automatic run_sar(input logic [W-1:0] v);
        int s, rv0, cap0;
        vin = v;
        trials.delete();
        rv0  = rv_count;
        cap0 = cap_count;
        s    = cyc;
        exp_q.push_back('{s + 50, s + 50, v, v, 1'b0});
        start = 1'b1; mode_sel = 1'b1;
        tick(1);
        start = 1'b0; mode_sel = 1'b0;
        check("sar_busy", 32'(busy), 32'd1);
        check("sar_gen_mode", 32'({gen_enable, adc_mode}), 32'h3);
        tick(52);
        check("sar_valid_count", 32'(rv_count - rv0), 32'd1);
        check("sar_no_capture", 32'(cap_count - cap0), 32'd0);
        check_trials(v, 1);
    endtask

    task automatic wait_valid(input int base, input int bound);
        int n;
        n = 0;
        while (rv_count == base && n < bound) begin
            tick(1);
            n++;
        end
        check("valid_within_bound", 32'(rv_count != base), 32'd1);
        tick(2);
    endtask

    logic [W-1:0] pin_tab [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    initial begin
        int s, rv0, cap0;
        reset = 1'b0; start = 1'b0; mode_sel = 1'b0; abort = 1'b0;
        for (int k = 0; k < 8; k++)
            check("model_pin_a5", 32'(sar_trial(8'hA5, k)), 32'(pin_tab[k]));
        check("model_pin_ff", 32'(sar_trial(8'hFF, 7)), 32'hFF);
        check("model_pin_00", 32'(sar_trial(8'h00, 7)), 32'h01);
        tick(3);
        check("reset_outputs", {16'h0, gen_enable, adc_mode, capture_en, busy, result_valid, overrange, 2'b00, result}, 32'h0);
        check("reset_duty", 32'(sar_duty_cycle), 32'h0);
        reset = 1'b1;
        tick(2);

        run_sar(8'hA5);
        check("sar_a5_result", 32'(result), 32'hA5);
        run_sar(8'h5A);
        run_sar(8'h00);
        run_sar(8'hFF);

        // Ramp conversion crossing at 0x3C.
        vin = 8'h3C; rv0 = rv_count; cap0 = cap_count; s = cyc;
        exp_q.push_back('{s + S + 5, s + S + T + 1, 8'h3C, 8'h3E, 1'b0});
        start = 1'b1; mode_sel = 1'b0;
        tick(1);
        start = 1'b0;
        check("ramp_gen_mode", 32'({gen_enable, adc_mode, busy}), 32'h5);
        wait_valid(rv0, T + 100);
        check("ramp_one_capture", 32'(cap_count - cap0), 32'd1);

        // Ramp overrange with the comparator stuck high.
        comp_force = 1'b1; rv0 = rv_count; s = cyc;
        exp_q.push_back('{s + S + T + 2, s + S + T + 2, 8'hFF, 8'hFF, 1'b1});
        start = 1'b1; mode_sel = 1'b0;
        tick(1);
        start = 1'b0;
        wait_valid(rv0, T + 100);
        comp_force = 1'b0;
        check("overrange_result", 32'({overrange, result}), 32'h1FF);

        // Abort during SAR bit 3 after a completed 0xA5 conversion.
        run_sar(8'hA5);
        rv0 = rv_count; s = cyc;
        start = 1'b1; mode_sel = 1'b1;
        tick(1);
        start = 1'b0;
        tick(25);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy_gen", 32'({busy, gen_enable}), 32'h0);
        tick(60);
        check("abort_no_valid", 32'(rv_count - rv0), 32'd0);
        check("abort_result_kept", 32'({overrange, result}), 32'h0A5);

        // Starts every cycle through a conversion, the last landing the cycle after DONE.
        vin = 8'h5A; trials.delete(); rv0 = rv_count; s = cyc;
        exp_q.push_back('{s + 50, s + 50, 8'h5A, 8'h5A, 1'b0});
        exp_q.push_back('{s + 100, s + 100, 8'h5A, 8'h5A, 1'b0});
        for (int k = 0; k <= 50; k++) begin
            start = 1'b1;
            mode_sel = (k % 2 == 0) ? 1'b1 : 1'b0;
            if (k == 25) check("busy_mode_held", 32'({busy, adc_mode}), 32'h3);
            if (k == 49) check("busy_in_done", 32'(busy), 32'd1);
            if (k == 50) check("idle_after_done", 32'(busy), 32'd0);
            tick(1);
        end
        start = 1'b0; mode_sel = 1'b0;
        check("back_to_back_start", 32'(busy), 32'd1);
        tick(55);
        check("back_to_back_count", 32'(rv_count - rv0), 32'd2);
        check_trials(8'h5A, 2);

        // Reset mid-SAR, then a start one cycle after release.
        rv0 = rv_count;
        start = 1'b1; mode_sel = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {16'h0, gen_enable, adc_mode, capture_en, busy, result_valid, overrange, 2'b00, result}, 32'h0);
        check("async_reset_duty", 32'(sar_duty_cycle), 32'h0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("post_reset_outputs", {16'h0, gen_enable, adc_mode, capture_en, busy, result_valid, overrange, 2'b00, result}, 32'h0);
        vin = 8'hA5; trials.delete(); cap0 = cap_count; s = cyc;
        exp_q.push_back('{s + 50, s + 50, 8'hA5, 8'hA5, 1'b0});
        start = 1'b1; mode_sel = 1'b1;
        tick(1);
        start = 1'b0;
        check("post_reset_start", 32'(busy), 32'd1);
        tick(55);
        check("post_reset_valid", 32'(rv_count - rv0), 32'd1);
        check_trials(8'hA5, 1);

        // Start and abort together in IDLE: start wins; a later abort cancels.
        start = 1'b1; abort = 1'b1; mode_sel = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("start_beats_abort", 32'(busy), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_to_idle", 32'({busy, gen_enable}), 32'h0);
        tick(5);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
